// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
package mem_pkg;

    localparam logic [2:0]  SIZE_BYTE   = 3'b001;
    localparam logic [2:0]  SIZE_HALF   = 3'b010;
    localparam logic [2:0]  SIZE_WORD   = 3'b100;
    // IO space is selected by address bits [17:16] of this base.
    localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSB = 1'b1
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] code);
        case (code)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the last-grant register moves only when a grant is taken.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rdy,
    input  logic i_req_if,
    input  logic i_req_lsb,
    input  logic i_accept,
    output logic o_valid,
    output req_t o_grant
);

    req_t r_last;

    // Reset to REQ_IF so the LSB wins the first tie.
    always_comb begin
        o_valid = i_req_if | i_req_lsb;
        if (i_req_if && i_req_lsb) begin
            o_grant = (r_last == REQ_IF) ? REQ_LSB : REQ_IF;
        end else if (i_req_lsb) begin
            o_grant = REQ_LSB;
        end else begin
            o_grant = REQ_IF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= REQ_IF;
        end else if (i_rdy && i_accept && o_valid) begin
            r_last <= o_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between fetch and the LSB, serialising 1/2/4-byte accesses.
// Build option MEM_IO_STALL_EN: hold IO stores in IDLE while io_buffer_full is set.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_flag,
    input  logic              io_buffer_full,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_enable,
    input  logic              lsb_wr,
    input  logic [2:0]        lsb_size,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    state_t            r_state;
    req_t              r_req;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [23:0]       r_wdata;
    logic [31:0]       r_buf;

    logic              w_is_io;
    logic              w_io_stall;
    logic              w_if_req;
    logic              w_lsb_req;
    logic              w_valid;
    req_t              w_grant;
    logic [31:0]       w_buf_next;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_is_io = (lsb_addr[17:16] == IO_BASE[17:16]);

`ifdef MEM_IO_STALL_EN
    assign w_io_stall = lsb_enable & lsb_wr & w_is_io & io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = io_buffer_full | w_is_io;
    assign w_io_stall  = 1'b0;
`endif

    // A flush only blocks new reads; a committed store is still taken.
    assign w_if_req    = if_enable & ~jump_flag;
    assign w_lsb_req   = lsb_enable & (lsb_wr | ~jump_flag) & ~w_io_stall;
    assign w_addr_next = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);

    rr_arbiter2 u_rr (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_rdy     (rdy),
        .i_req_if  (w_if_req),
        .i_req_lsb (w_lsb_req),
        .i_accept  (r_state == IDLE),
        .o_valid   (w_valid),
        .o_grant   (w_grant)
    );

    // mem_din answers the address of the previous cycle, so it lands in lane cnt-1.
    always_comb begin
        w_buf_next = r_buf;
        case (r_cnt)
            3'd1:    w_buf_next[7:0]   = mem_din;
            3'd2:    w_buf_next[15:8]  = mem_din;
            3'd3:    w_buf_next[23:16] = mem_din;
            3'd4:    w_buf_next[31:24] = mem_din;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_req     <= REQ_IF;
            r_base    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_wdata   <= '0;
            r_buf     <= '0;
            mem_wr    <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_req <= w_grant;
                        r_cnt <= '0;
                        r_buf <= '0;
                        if (w_grant == REQ_LSB) begin
                            r_base <= lsb_addr;
                            r_len  <= size_bytes(lsb_size);
                            mem_a  <= lsb_addr;
                            if (lsb_wr) begin
                                mem_wr   <= 1'b1;
                                mem_dout <= lsb_wdata[7:0];
                                r_wdata  <= lsb_wdata[31:8];
                                r_state  <= WRITE;
                            end else begin
                                r_state  <= READ;
                            end
                        end else begin
                            r_base  <= if_addr;
                            r_len   <= 3'd4;
                            mem_a   <= if_addr;
                            r_state <= READ;
                        end
                    end
                end
                READ: begin
                    if (jump_flag) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == r_len) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        if (r_req == REQ_IF) begin
                            if_done <= 1'b1;
                            if_data <= w_buf_next;
                        end else begin
                            lsb_done  <= 1'b1;
                            lsb_rdata <= w_buf_next;
                        end
                    end else begin
                        r_buf <= w_buf_next;
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt + 3'd1 < r_len) begin
                            mem_a <= w_addr_next;
                        end
                    end
                end
                WRITE: begin
                    if (r_cnt + 3'd1 < r_len) begin
                        mem_a    <= w_addr_next;
                        mem_dout <= r_wdata[7:0];
                        r_wdata  <= {8'h00, r_wdata[23:8]};
                        r_cnt    <= r_cnt + 3'd1;
                    end else begin
                        mem_wr   <= 1'b0;
                        r_state  <= DONE;
                        r_cnt    <= '0;
                        lsb_done <= 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions and writes.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_flag;
    logic        io_buffer_full;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_enable;
    logic        lsb_wr;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    typedef struct {
        bit          is_lsb;
        bit          has_data;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          cyc;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];
    done_t de;
    wr_t   we;
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    t;
    logic [7:0] ram [0:4095];

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .jump_flag      (jump_flag),
        .io_buffer_full (io_buffer_full),
        .if_enable      (if_enable),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_enable     (lsb_enable),
        .lsb_wr         (lsb_wr),
        .lsb_size       (lsb_size),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_done       (lsb_done),
        .lsb_rdata      (lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM bus shares the global enable; contents are preloaded while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13;
            ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h10;
            ram[12'h103] <= 8'h00;
            mem_din <= 8'h00;
        end else if (rdy) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a completion or a write.
    always @(negedge clk) begin
        if (rst) begin
            if (if_done || lsb_done) begin
                if (dq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: if_done=%0b lsb_done=%0b at cycle %0d, none required",
                             if_done, lsb_done, cyc);
                end else begin
                    de = dq.pop_front();
                    chk("done_lsb", {31'd0, lsb_done}, {31'd0, de.is_lsb});
                    chk("done_if", {31'd0, if_done}, {31'd0, ~de.is_lsb});
                    chk("done_cycle", 32'(cyc), 32'(de.cyc));
                    if (de.has_data) chk("done_data", de.is_lsb ? lsb_rdata : if_data, de.data);
                end
            end
            if (mem_wr) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %h data %h at cycle %0d, none required",
                             mem_a, mem_dout, cyc);
                end else begin
                    we = wq.pop_front();
                    chk("wr_addr", mem_a, we.a);
                    chk("wr_data", {24'd0, mem_dout}, {24'd0, we.d});
                    chk("wr_cycle", 32'(cyc), 32'(we.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_done(input bit is_lsb, input bit has_data, input logic [31:0] d, input int c);
        done_t e;
        e.is_lsb = is_lsb; e.has_data = has_data; e.data = d; e.cyc = c;
        dq.push_back(e);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int c);
        wr_t e;
        e.a = a; e.d = d; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic lsb_req(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        lsb_enable = 1'b1; lsb_wr = wr; lsb_size = sz; lsb_addr = a; lsb_wdata = wd;
    endtask

    task automatic if_req(input logic [31:0] a);
        if_enable = 1'b1; if_addr = a;
    endtask

    task automatic wait_done(input bit is_lsb, input int budget);
        int n = 0;
        while (!(is_lsb ? lsb_done : if_done) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout_%s: no done within %0d cycles, required one", is_lsb ? "lsb" : "if", budget);
        end
    endtask

    task automatic lsb_drop();
        lsb_enable = 1'b0; lsb_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
        if_enable = 1'b0; if_addr = '0;
        lsb_enable = 1'b0; lsb_wr = 1'b0; lsb_size = 3'b001; lsb_addr = '0; lsb_wdata = '0;
        repeat (3) step();
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst = 1'b1;
        step();

        // Tie from reset: LSB byte load first, then the fetch.
        t = cyc;
        if_req(32'h100);
        lsb_req(1'b0, 3'b001, 32'h101, 32'h0);
        exp_done(1'b1, 1'b1, 32'h0000_0005, t + 3);
        exp_done(1'b0, 1'b1, 32'h0010_0513, t + 10);
        wait_done(1'b1, 20); lsb_drop();
        wait_done(1'b0, 20); if_enable = 1'b0;
        step();

        // Next tie after a fetch grant goes to the LSB again.
        t = cyc;
        if_req(32'h100);
        lsb_req(1'b0, 3'b010, 32'h102, 32'h0);
        exp_done(1'b1, 1'b1, 32'h0000_0010, t + 4);
        exp_done(1'b0, 1'b1, 32'h0010_0513, t + 11);
        wait_done(1'b1, 20); lsb_drop();
        wait_done(1'b0, 20); if_enable = 1'b0;
        step();

        // Halfword store, then read it back.
        t = cyc;
        lsb_req(1'b1, 3'b010, 32'h200, 32'hABCD_1234);
        exp_wr(32'h200, 8'h34, t + 1);
        exp_wr(32'h201, 8'h12, t + 2);
        exp_done(1'b1, 1'b0, 32'h0, t + 3);
        wait_done(1'b1, 20); lsb_drop();
        step();
        t = cyc;
        lsb_req(1'b0, 3'b010, 32'h200, 32'h0);
        exp_done(1'b1, 1'b1, 32'h0000_1234, t + 4);
        wait_done(1'b1, 20); lsb_drop();
        step();

        // Flush during a fetch read: no if_done, IDLE again at T+3.
        t = cyc;
        if_req(32'h100);
        step(); step();
        jump_flag = 1'b1; if_enable = 1'b0;
        step();
        jump_flag = 1'b0;
        lsb_req(1'b0, 3'b001, 32'h100, 32'h0);
        exp_done(1'b1, 1'b1, 32'h0000_0013, t + 6);
        wait_done(1'b1, 20); lsb_drop();
        step();

        // Flush during a word store does not stop it.
        t = cyc;
        lsb_req(1'b1, 3'b100, 32'h300, 32'h1122_3344);
        exp_wr(32'h300, 8'h44, t + 1);
        exp_wr(32'h301, 8'h33, t + 2);
        exp_wr(32'h302, 8'h22, t + 3);
        exp_wr(32'h303, 8'h11, t + 4);
        exp_done(1'b1, 1'b0, 32'h0, t + 5);
        step(); step();
        jump_flag = 1'b1;
        step();
        jump_flag = 1'b0;
        wait_done(1'b1, 20); lsb_drop();
        step();

        // Flush in IDLE blocks the fetch but lets the store in.
        t = cyc;
        jump_flag = 1'b1;
        if_req(32'h100);
        lsb_req(1'b1, 3'b001, 32'h304, 32'h0000_00EE);
        exp_wr(32'h304, 8'hEE, t + 1);
        exp_done(1'b1, 1'b0, 32'h0, t + 2);
        exp_done(1'b0, 1'b1, 32'h0010_0513, t + 9);
        step();
        jump_flag = 1'b0;
        wait_done(1'b1, 20); lsb_drop();
        wait_done(1'b0, 20); if_enable = 1'b0;
        step();

        // Flush in IDLE delays an LSB load by one cycle.
        t = cyc;
        jump_flag = 1'b1;
        lsb_req(1'b0, 3'b001, 32'h100, 32'h0);
        exp_done(1'b1, 1'b1, 32'h0000_0013, t + 4);
        step();
        jump_flag = 1'b0;
        wait_done(1'b1, 20); lsb_drop();
        step();

        // Unlisted size code reads a whole word.
        t = cyc;
        lsb_req(1'b0, 3'b011, 32'h300, 32'h0);
        exp_done(1'b1, 1'b1, 32'h1122_3344, t + 6);
        wait_done(1'b1, 20); lsb_drop();
        step();

        // rdy low for 3 cycles mid-read delays done by exactly 3.
        t = cyc;
        if_req(32'h100);
        exp_done(1'b0, 1'b1, 32'h0010_0513, t + 9);
        step(); step();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        wait_done(1'b0, 20); if_enable = 1'b0;
        step();

        // Address increment wraps at 32 bits.
        t = cyc;
        lsb_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h0000_BEEF);
        exp_wr(32'hFFFF_FFFF, 8'hEF, t + 1);
        exp_wr(32'h0000_0000, 8'hBE, t + 2);
        exp_done(1'b1, 1'b0, 32'h0, t + 3);
        wait_done(1'b1, 20); lsb_drop();
        step();

        // IO store with the UART buffer full.
        t = cyc;
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 3'b001, 32'h0003_0000, 32'h0000_005A);
`ifdef MEM_IO_STALL_EN
        exp_wr(32'h0003_0000, 8'h5A, t + 6);
        exp_done(1'b1, 1'b0, 32'h0, t + 7);
        repeat (5) step();
        io_buffer_full = 1'b0;
`else
        exp_wr(32'h0003_0000, 8'h5A, t + 1);
        exp_done(1'b1, 1'b0, 32'h0, t + 2);
`endif
        wait_done(1'b1, 20); lsb_drop();
        io_buffer_full = 1'b0;
        repeat (5) step();

        chk("pending_done", 32'(dq.size()), 32'd0);
        chk("pending_write", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM/IO port between instruction fetch and the load/store buffer. Each granted access of 1, 2 or 4 bytes is split into sequential byte transactions, reads are reassembled little-endian, and one completion pulse is returned to the winner. The block sits between the fetch unit, the LSB, and the top-level RAM bus, and observes the pipeline flush (`jump_flag`).

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `IO_BASE`, 32'h30000, start of memory-mapped IO; IO when `addr[17:16]==2'b11`

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `rdy`  in  1  global enable; when 0 every register holds its value
- `jump_flag`  in  1  flush from ROB mispredict
- `io_buffer_full`  in  1  UART buffer full
- `if_enable`  in  1  fetch request, level, held until `if_done`
- `if_addr`  in  32  fetch word address
- `if_done`  out  1  one-cycle completion pulse
- `if_data`  out  32  fetched word, valid with `if_done`
- `lsb_enable`  in  1  LSB request, level, held until `lsb_done`
- `lsb_wr`  in  1  1 = store, 0 = load
- `lsb_size`  in  3  3'b001 = byte, 3'b010 = half, 3'b100 = word; other codes treated as word
- `lsb_addr`  in  32  byte address
- `lsb_wdata`  in  32  store data, low bytes used
- `lsb_done`  out  1  one-cycle completion pulse
- `lsb_rdata`  out  32  load data, zero-extended, valid with `lsb_done`
- `mem_din`  in  8  RAM read byte, valid one cycle after `mem_a`
- `mem_dout`  out  8  RAM write byte
- `mem_a`  out  32  RAM byte address
- `mem_wr`  out  1  1 = write this cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - Samples both requests and picks one with round-robin priority.
  - On a tie, the requester not served last wins. `last_grant` resets so that the LSB wins the first tie.
  - Latches address, size N, write data and requester, sets byte counter to 0, then enters READ or WRITE.
- **READ**
  - Drives `mem_a = base + cnt` for cnt = 0..N-1, one byte per cycle.
  - Captures `mem_din` one cycle after each address into byte lane cnt-1.
  - After the last byte is captured, enters DONE.
- **WRITE**
  - Drives `mem_wr=1`, `mem_a = base + cnt` and `mem_dout = wdata[8cnt+7:8cnt]` for N cycles.
  - Then enters DONE with `mem_wr=0`.
- **DONE**
  - Pulses the winner's `*_done` with data and returns to IDLE.
  - Requests are ignored in this cycle, because requesters drop `enable` one cycle after seeing `done`.
- **Byte assembly**
  - Little-endian; unreceived upper bytes are 0.
  - Address increment is a 32-bit wrap with no carry check.
- **Flush**
  - `jump_flag` during a READ (either requester) aborts it: next state IDLE, no `done` pulse, counter cleared.
  - `jump_flag` during a WRITE has no effect: the committed store completes and `lsb_done` pulses.
  - In IDLE, `jump_flag` blocks acceptance of fetches and LSB loads that cycle. LSB stores are still accepted.
- **Reset values**
  - `mem_wr=0`, `mem_a=0`, `mem_dout=0`, `if_done=0`, `lsb_done=0`, `if_data=0`, `lsb_rdata=0`.
  - State IDLE, counter 0.
  - Reset mid-transaction abandons it without any `done` pulse.

## Timing
- Request first seen in IDLE at cycle T.
- Read of N bytes:
  - `mem_a` for byte 0 is driven at T+1.
  - `done` and data are visible at T+N+2, so a word read occupies 6 cycles.
- Write of N bytes:
  - `mem_wr` is high from T+1 to T+N.
  - `done` is visible at T+N+1.
- Next acceptance is no earlier than the cycle after DONE.
- All outputs are registered.
- `rdy=0` freezes state, counter and outputs, including a held `mem_wr`; a rewrite of the same byte is benign.

## Configuration
- `MEM_IO_STALL_EN`
  - Defined: an LSB store to an IO address is not accepted in IDLE while `io_buffer_full=1`, and a pending fetch may be granted instead. While stalled, `lsb_done` stays 0.
  - Undefined: `io_buffer_full` is ignored and IO stores proceed immediately.

## Structure
- Shared package `mem_pkg`:
  - size codes
  - state enum
  - `IO_BASE` / IO-decode constant
  - requester IDs (`REQ_IF`, `REQ_LSB`)
- One natural sub-module, `rr_arbiter2`: a two-input round-robin grant with an internal last-grant register, updated only on acceptance.

## Test plan
- **Fetch read:** RAM holds bytes 0x13, 0x05, 0x10, 0x00 at 0x100; `if_enable`, `if_addr=0x100` at T -> `if_done` at T+6, `if_data=0x00100513`.
- **LSB halfword store:** `lsb_wr=1`, `size=010`, `addr=0x200`, `wdata=0xABCD1234` -> `mem_wr` at T+1 with (0x200, 0x34) and at T+2 with (0x201, 0x12); `lsb_done` at T+3.
- **Simultaneous requests from reset:** LSB byte load granted first, `lsb_done` at T+3. The fetch is then granted and completes; with both re-requesting afterwards, the next tie goes to the LSB again.
- **Flush mid-read:** `jump_flag` at T+2 of a fetch -> IDLE at T+3, no `if_done`. Flush at T+2 of a word store -> all 4 writes occur, `lsb_done` at T+5.
- **IO stall (`MEM_IO_STALL_EN`):** store to 0x30000 with `io_buffer_full=1` for 5 cycles -> no `mem_wr` until the cycle after full drops, then `lsb_done` 2 cycles later.
- **`rdy` low for 3 cycles during a word read:** `done` is delayed by exactly 3 cycles and the data is unchanged.
